tone_player: RTL and testbench

TONE_PLAYER -- requirements
Module: tone_player

---
 rtl/tone_player_if.sv | 27 ++
 rtl/tone_player.sv | 179 +++++++++++++++++
 tb/tb_tone_player.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tone_player_if.sv
// rtl/tone_player_if.sv - note code handshake between a sequencer and tone_player
//
// Signals:
//   noteValid  : sequencer -> player, noteSelect holds a valid code
//   noteSelect : sequencer -> player, 4-bit note code (0-6 A..G, 7 rest, 8-15 end)
//   noteReady  : player -> sequencer, a code can be accepted this cycle
//   noteDone   : player -> sequencer, one-cycle pulse when a code finishes
interface tone_player_if;
  logic       noteValid;
  logic [3:0] noteSelect;
  logic       noteReady;
  logic       noteDone;

  modport master (
    output noteValid,
    output noteSelect,
    input  noteReady,
    input  noteDone
  );

  modport slave (
    input  noteValid,
    input  noteSelect,
    output noteReady,
    output noteDone
  );
endinterface

// File: rtl/tone_player.sv
// rtl/tone_player.sv - square-wave note player with fixed note and gap durations
//
// Ports:
//   clk         : single clock, rising edge
//   reset       : asynchronous active-low reset
//   note        : tone_player_if.slave, noteValid/noteSelect in, noteReady/noteDone out
//   stop        : abort the current note and return to IDLE on the next edge
//   audioOut    : square-wave speaker drive
//   audioEnable : amplifier enable, high only while a tone (not a rest) plays
//   busy        : high whenever the player is not IDLE
module tone_player #(
  parameter int unsigned CLK_HZ      = 100000000,
  parameter int unsigned NOTE_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES  = 2500000
) (
  input  logic          clk,
  input  logic          reset,
  tone_player_if.slave  note,
  input  logic          stop,
  output logic          audioOut,
  output logic          audioEnable,
  output logic          busy
);

  // Half-period, in clk cycles, of each tone A..G (integer division).
  localparam logic [31:0] HALF_A = 32'(CLK_HZ / (2 * 440));
  localparam logic [31:0] HALF_B = 32'(CLK_HZ / (2 * 494));
  localparam logic [31:0] HALF_C = 32'(CLK_HZ / (2 * 523));
  localparam logic [31:0] HALF_D = 32'(CLK_HZ / (2 * 587));
  localparam logic [31:0] HALF_E = 32'(CLK_HZ / (2 * 659));
  localparam logic [31:0] HALF_F = 32'(CLK_HZ / (2 * 698));
  localparam logic [31:0] HALF_G = 32'(CLK_HZ / (2 * 784));

  // Terminal counts of the duration counter. GAP_LAST is unused when
  // GAP_CYCLES is zero, since PLAY then goes straight to DONE.
  localparam logic [31:0] NOTE_LAST = 32'(NOTE_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
  localparam bit          HAS_GAP   = (GAP_CYCLES != 0);

  localparam logic [3:0]  CODE_REST = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  code_q;
  logic [31:0] dur_cnt;
  logic [31:0] tone_cnt;
  logic        done_q;
  logic        audio_q;
  logic        enable_q;
  logic        busy_q;

  logic        accept;
  logic [31:0] half_last;

  // A rest has no pitch; its tone counter still runs but never toggles the
  // output, so any non-zero half-period is fine for it.
  function automatic logic [31:0] half_of(input logic [3:0] code);
    case (code)
      4'd0:    half_of = HALF_A;
      4'd1:    half_of = HALF_B;
      4'd2:    half_of = HALF_C;
      4'd3:    half_of = HALF_D;
      4'd4:    half_of = HALF_E;
      4'd5:    half_of = HALF_F;
      4'd6:    half_of = HALF_G;
      default: half_of = 32'd1;
    endcase
  endfunction

  assign note.noteReady = (state == IDLE) && !stop;
  assign accept         = note.noteValid && note.noteReady;
  assign half_last      = half_of(code_q) - 32'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      code_q   <= 4'd0;
      dur_cnt  <= 32'd0;
      tone_cnt <= 32'd0;
      done_q   <= 1'b0;
      audio_q  <= 1'b0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q   <= 1'b0;
          audio_q  <= 1'b0;
          enable_q <= 1'b0;
          dur_cnt  <= 32'd0;
          tone_cnt <= 32'd0;
          busy_q   <= 1'b0;
          if (accept) begin
            code_q <= note.noteSelect;
            busy_q <= 1'b1;
            if (note.noteSelect[3]) begin
              // End/invalid codes skip straight to the completion pulse.
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state    <= PLAY;
              enable_q <= (note.noteSelect != CODE_REST);
            end
          end
        end

        PLAY: begin
          if (stop) begin
            state    <= IDLE;
            dur_cnt  <= 32'd0;
            tone_cnt <= 32'd0;
            audio_q  <= 1'b0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
          end else if (dur_cnt == NOTE_LAST) begin
            dur_cnt  <= 32'd0;
            tone_cnt <= 32'd0;
            audio_q  <= 1'b0;
            enable_q <= 1'b0;
            if (HAS_GAP) begin
              state <= GAP;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end else begin
            dur_cnt <= dur_cnt + 32'd1;
            if (tone_cnt == half_last) begin
              tone_cnt <= 32'd0;
              audio_q  <= (code_q != CODE_REST) ? ~audio_q : 1'b0;
            end else begin
              tone_cnt <= tone_cnt + 32'd1;
            end
          end
        end

        GAP: begin
          if (stop) begin
            state   <= IDLE;
            dur_cnt <= 32'd0;
            busy_q  <= 1'b0;
          end else if (dur_cnt == GAP_LAST) begin
            state   <= DONE;
            dur_cnt <= 32'd0;
            done_q  <= 1'b1;
          end else begin
            dur_cnt <= dur_cnt + 32'd1;
          end
        end

        DONE: begin
          // DONE always lasts one cycle, so stop and the normal exit coincide.
          state   <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          dur_cnt <= 32'd0;
        end

        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign note.noteDone = done_q;
  assign audioOut      = audio_q;
  assign audioEnable   = enable_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_tone_player.sv
// tb/tb_tone_player.sv - directed self-checking bench for tone_player
module tb_tone_player;
  logic clk;
  logic reset;
  logic stop;
  logic audioOut;
  logic audioEnable;
  logic busy;

  int total;
  int bad;

  tone_player_if nif ();

  tone_player #(
    .CLK_HZ      (8800),
    .NOTE_CYCLES (100),
    .GAP_CYCLES  (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .note        (nif.slave),
    .stop        (stop),
    .audioOut    (audioOut),
    .audioEnable (audioEnable),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a code at a falling edge; returns at the falling edge of the
  // first cycle after the accepting rising edge (cycle 1).
  task automatic start_note(input logic [3:0] code);
    nif.noteSelect = code;
    nif.noteValid  = 1'b1;
    @(negedge clk);
    nif.noteValid  = 1'b0;
  endtask

  task automatic test_reset;
    logic [4:0] obs;
    reset = 1'b0;
    stop = 1'b0;
    nif.noteValid = 1'b0;
    nif.noteSelect = 4'd0;
    @(negedge clk);
    obs = {busy, audioEnable, audioOut, nif.noteDone, nif.noteReady};
    total++;
    if (obs !== 5'b00001) begin
      bad++;
      $display("FAIL reset_state: got %b want 00001", obs);
    end
    stop = 1'b1;
    #1;
    total++;
    if (nif.noteReady !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready_stop: got %b want 0", nif.noteReady);
    end
    stop = 1'b0;
    @(negedge clk);
    // Release with an end code already presented: accepted on the first edge.
    nif.noteSelect = 4'd8;
    nif.noteValid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    nif.noteValid = 1'b0;
    obs = {busy, audioEnable, audioOut, nif.noteDone, nif.noteReady};
    total++;
    if (obs !== 5'b10010) begin
      bad++;
      $display("FAIL end_code_done: got %b want 10010", obs);
    end
    @(negedge clk);
    obs = {busy, audioEnable, audioOut, nif.noteDone, nif.noteReady};
    total++;
    if (obs !== 5'b00001) begin
      bad++;
      $display("FAIL end_code_ready: got %b want 00001", obs);
    end
  endtask

  task automatic test_tone_a;
    logic [4:0] obs;
    logic [4:0] exp_v;
    logic       prev;
    logic       e_out;
    int         toggles;
    int         dones;
    prev = 1'b0;
    toggles = 0;
    dones = 0;
    start_note(4'd0);
    for (int k = 1; k <= 112; k++) begin
      e_out = (k <= 100) && ((((k - 1) / 10) % 2) == 1);
      exp_v = {k <= 111, k <= 100, e_out, k == 111, k == 112};
      obs = {busy, audioEnable, audioOut, nif.noteDone, nif.noteReady};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL tone_a cycle %0d: got %b want %b", k, obs, exp_v);
      end
      if (k <= 101 && audioOut !== prev) toggles++;
      prev = audioOut;
      if (nif.noteDone === 1'b1) dones++;
      @(negedge clk);
    end
    total++;
    if (toggles != 10) begin
      bad++;
      $display("FAIL tone_a_toggles: got %0d want 10", toggles);
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL tone_a_done_count: got %0d want 1", dones);
    end
  endtask

  task automatic test_rest;
    logic [4:0] obs;
    logic [4:0] exp_v;
    start_note(4'd7);
    for (int k = 1; k <= 112; k++) begin
      exp_v = {k <= 111, 1'b0, 1'b0, k == 111, k == 112};
      obs = {busy, audioEnable, audioOut, nif.noteDone, nif.noteReady};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL rest cycle %0d: got %b want %b", k, obs, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stop;
    logic [4:0] obs;
    int         dones;
    dones = 0;
    start_note(4'd0);
    for (int k = 1; k < 40; k++) @(negedge clk);
    // Cycle 40 of PLAY: fourth half-period, output high.
    obs = {busy, audioEnable, audioOut, nif.noteDone, nif.noteReady};
    total++;
    if (obs !== 5'b11100) begin
      bad++;
      $display("FAIL stop_before: got %b want 11100", obs);
    end
    stop = 1'b1;
    @(negedge clk);
    obs = {busy, audioEnable, audioOut, nif.noteDone, nif.noteReady};
    total++;
    if (obs !== 5'b00000) begin
      bad++;
      $display("FAIL stop_idle: got %b want 00000", obs);
    end
    // stop and noteValid together in IDLE must not start anything.
    nif.noteSelect = 4'd0;
    nif.noteValid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      obs = {busy, audioEnable, audioOut, nif.noteDone, nif.noteReady};
      total++;
      if (obs !== 5'b00000) begin
        bad++;
        $display("FAIL stop_no_accept %0d: got %b want 00000", k, obs);
      end
    end
    nif.noteValid = 1'b0;
    stop = 1'b0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (nif.noteDone === 1'b1 || busy === 1'b1) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL stop_no_done: got %0d active cycles want 0", dones);
    end
  endtask

  task automatic test_reset_mid_play;
    logic [4:0] obs;
    logic [4:0] exp_v;
    logic       e_out;
    start_note(4'd0);
    for (int k = 1; k < 15; k++) @(negedge clk);
    total++;
    if (audioOut !== 1'b1) begin
      bad++;
      $display("FAIL mid_play_out: got %b want 1", audioOut);
    end
    #2;
    reset = 1'b0;
    #1;
    obs = {busy, audioEnable, audioOut, nif.noteDone, nif.noteReady};
    total++;
    if (obs !== 5'b00001) begin
      bad++;
      $display("FAIL async_reset: got %b want 00001", obs);
    end
    @(negedge clk);
    reset = 1'b1;
    start_note(4'd6);
    for (int k = 1; k <= 112; k++) begin
      e_out = (k <= 100) && ((((k - 1) / 5) % 2) == 1);
      exp_v = {k <= 111, k <= 100, e_out, k == 111, k == 112};
      obs = {busy, audioEnable, audioOut, nif.noteDone, nif.noteReady};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL tone_g cycle %0d: got %b want %b", k, obs, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] obs;
    logic [4:0] exp_v;
    logic       e_out;
    logic [3:0] next_code [3];
    int         half_v [3];
    int         dones;
    next_code[0] = 4'd1;
    next_code[1] = 4'd2;
    next_code[2] = 4'd6;
    half_v[0] = 10;
    half_v[1] = 8;
    half_v[2] = 8;
    dones = 0;
    nif.noteSelect = 4'd0;
    nif.noteValid = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      for (int k = 1; k <= 112; k++) begin
        e_out = (k <= 100) && ((((k - 1) / half_v[n]) % 2) == 1);
        exp_v = {k <= 111, k <= 100, e_out, k == 111, k == 112};
        obs = {busy, audioEnable, audioOut, nif.noteDone, nif.noteReady};
        total++;
        if (obs !== exp_v) begin
          bad++;
          $display("FAIL b2b note %0d cycle %0d: got %b want %b", n, k, obs, exp_v);
        end
        if (nif.noteDone === 1'b1) dones++;
        if (n == 2 && k == 1) nif.noteValid = 1'b0;
        if (k == 5) nif.noteSelect = next_code[n];
        @(negedge clk);
      end
    end
    for (int k = 0; k < 5; k++) begin
      if (nif.noteDone === 1'b1 || busy === 1'b1) dones += 100;
      @(negedge clk);
    end
    total++;
    if (dones != 3) begin
      bad++;
      $display("FAIL b2b_done_count: got %0d want 3", dones);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset;
    test_tone_a;
    test_rest;
    test_stop;
    test_reset_mid_play;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
